// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   - mdop encodings driven by decode
//   - default latency constants
//   - sequencer state enum
//   - md_max: constant helper used to size the latency counter
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int unsigned MULT_CYCLES_D = 5;
  localparam int unsigned DIV_CYCLES_D  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic int unsigned md_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_div32.sv
// md_div32: combinational 32-bit divide, signed or unsigned.
// Ports:
//   i_signed    1  treat operands as two's complement
//   i_dividend  32 dividend
//   i_divisor   32 divisor (a zero divisor yields a defined but meaningless result)
//   o_quot      32 quotient, truncated toward zero
//   o_rem       32 remainder, carrying the dividend's sign
module md_div32 (
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_safe_b;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  assign w_neg_a = i_signed & i_dividend[31];
  assign w_neg_b = i_signed & i_divisor[31];

  // Divide magnitudes unsigned, then restore signs. 0x80000000 negates to
  // itself, which is the correct unsigned magnitude.
  assign w_abs_a = w_neg_a ? (32'd0 - i_dividend) : i_dividend;
  assign w_abs_b = w_neg_b ? (32'd0 - i_divisor)  : i_divisor;

  // Keep the divider free of X when the caller discards a divide-by-zero.
  assign w_safe_b = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;

  assign w_q_u = w_abs_a / w_safe_b;
  assign w_r_u = w_abs_a % w_safe_b;

  assign o_quot = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_u) : w_q_u;
  assign o_rem  = w_neg_a ? (32'd0 - w_r_u) : w_r_u;

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide sequencer owning the architectural HI/LO registers.
// Results are computed combinationally at start and parked in p_hi/p_lo; a
// down-counter models the latency and commits them to hi/lo when it expires.
// Ports:
//   clk      1  clock, rising edge
//   reset    1  synchronous, active-low
//   indata1  32 rs operand
//   indata2  32 rt operand
//   mdop     3  operation select (md_pkg encodings)
//   start    1  qualifies mdop/operands; ignored while busy or in reset
//   busy     1  multi-cycle operation in flight (registered)
//   hi, lo   32 architectural HI/LO (registered)
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_D,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] indata1,
  input  logic [31:0] indata2,
  input  logic [2:0]  mdop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntMax = md_max(MULT_CYCLES, DIV_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  md_state_e       r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]     r_p_hi, w_p_hi_nxt;
  logic [31:0]     r_p_lo, w_p_lo_nxt;
  logic [31:0]     r_hi, w_hi_nxt;
  logic [31:0]     r_lo, w_lo_nxt;

  logic        w_is_mult;
  logic        w_is_div;
  logic [63:0] w_op1_64;
  logic [63:0] w_op2_64;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_is_mult = (mdop == MD_MULT) | (mdop == MD_MULTU);
  assign w_is_div  = (mdop == MD_DIV)  | (mdop == MD_DIVU);

  // Extend to 64 bits first; the low 64 bits of the product are then exact
  // for both signed and unsigned interpretations.
  assign w_op1_64 = (mdop == MD_MULT) ? {{32{indata1[31]}}, indata1} : {32'd0, indata1};
  assign w_op2_64 = (mdop == MD_MULT) ? {{32{indata2[31]}}, indata2} : {32'd0, indata2};
  assign w_prod   = w_op1_64 * w_op2_64;

  md_div32 u_div (
    .i_signed   (mdop == MD_DIV),
    .i_dividend (indata1),
    .i_divisor  (indata2),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MD_IDLE: if (start && (w_is_mult || w_is_div)) w_state_nxt = MD_RUN;
      MD_RUN:  if (r_cnt == CntOne) w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (r_state == MD_RUN);
    hi   = r_hi;
    lo   = r_lo;
  end

  // Datapath next values
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_p_hi_nxt = r_p_hi;
    w_p_lo_nxt = r_p_lo;
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    if (r_state == MD_IDLE) begin
      if (start) begin
        case (mdop)
          MD_MULT, MD_MULTU: begin
            w_cnt_nxt  = MultLoad;
            w_p_hi_nxt = w_prod[63:32];
            w_p_lo_nxt = w_prod[31:0];
          end
          MD_DIV, MD_DIVU: begin
            w_cnt_nxt = DivLoad;
            // Divide-by-zero recommits the current hi/lo, leaving them unchanged.
            if (indata2 != 32'd0) begin
              w_p_hi_nxt = w_rem;
              w_p_lo_nxt = w_quot;
            end else begin
              w_p_hi_nxt = r_hi;
              w_p_lo_nxt = r_lo;
            end
          end
          MD_MTHI: w_hi_nxt = indata1;
          MD_MTLO: w_lo_nxt = indata1;
          default: ;
        endcase
      end
    end else begin
      w_cnt_nxt = r_cnt - CntOne;
      if (r_cnt == CntOne) begin
        w_hi_nxt = r_p_hi;
        w_lo_nxt = r_p_lo;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_p_hi <= '0;
      r_p_lo <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_p_hi <= w_p_hi_nxt;
      r_p_lo <= w_p_lo_nxt;
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit. Stimulus pushes timed expectation events
// (busy on/off, hi/lo updates) into a queue; the monitor applies events as
// their cycle arrives and compares busy/hi/lo against them every cycle.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] indata1;
  logic [31:0] indata2;
  logic [2:0]  mdop;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .indata1 (indata1),
    .indata2 (indata2),
    .mdop    (mdop),
    .start   (start),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    bit          ub;
    bit          bv;
    bit          uh;
    bit          ul;
    logic [31:0] h;
    logic [31:0] l;
    string       name;
  } ev_t;

  ev_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;
  bit done   = 1'b0;

  logic        e_busy = 1'b0;
  logic [31:0] e_hi   = 32'd0;
  logic [31:0] e_lo   = 32'd0;
  string       e_tag  = "reset";

  function automatic ev_t mk(input int unsigned due, input bit ub, input bit bv, input bit uh,
                             input bit ul, input logic [31:0] h, input logic [31:0] l,
                             input string nm);
    ev_t e;
    e.due  = due;
    e.ub   = ub;
    e.bv   = bv;
    e.uh   = uh;
    e.ul   = ul;
    e.h    = h;
    e.l    = l;
    e.name = nm;
    return e;
  endfunction

  // Monitor: sample 1 time unit after the active edge.
  initial begin
    ev_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.ub) e_busy = e.bv;
        if (e.uh) e_hi = e.h;
        if (e.ul) e_lo = e.l;
        e_tag = e.name;
      end
      if (chk_en) begin
        n_vec++;
        if (busy !== e_busy || hi !== e_hi || lo !== e_lo) begin
          n_miss++;
          $display("FAIL %s @cycle %0d: got busy=%b hi=%h lo=%h, want busy=%b hi=%h lo=%h",
                   e_tag, cyc, busy, hi, lo, e_busy, e_hi, e_lo);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start   = 1'b0;
      mdop    = MD_NONE;
      indata1 = 32'd0;
      indata2 = 32'd0;
    end
  endtask

  // Issue an op in the current cycle T; lat=0 for mthi/mtlo.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned lat, input logic [31:0] rh, input logic [31:0] rl,
                       input string nm);
    @(negedge clk);
    start   = 1'b1;
    mdop    = op;
    indata1 = a;
    indata2 = b;
    if (lat > 0) begin
      sb.push_back(mk(cyc + 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, nm));
      sb.push_back(mk(cyc + lat + 1, 1'b1, 1'b0, 1'b1, 1'b1, rh, rl, nm));
    end else if (op == MD_MTHI) begin
      sb.push_back(mk(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, a, 32'd0, nm));
    end else if (op == MD_MTLO) begin
      sb.push_back(mk(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, a, nm));
    end
  endtask

  // Start while busy: an upstream violation the DUT must ignore.
  task automatic stray(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    start   = 1'b1;
    mdop    = op;
    indata1 = a;
    indata2 = 32'd0;
    $display("note: upstream violation, start with mdop=%0d while busy at cycle %0d", op, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    mdop  = MD_NONE;
    reset = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due > cyc) sb.delete(i);
    end
    sb.push_back(mk(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, "reset"));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    mdop    = MD_NONE;
    indata1 = 32'd0;
    indata2 = 32'd0;
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    issue(MD_MULT,  32'hFFFFFFFF, 32'h00000002, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
    idle(5);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE, "multu");
    idle(5);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    idle(5);
    issue(MD_MULT,  32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000, "mult_min");
    idle(5);
    issue(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    idle(10);
    issue(MD_DIVU,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003, "divu");
    idle(10);
    issue(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negdiv");
    idle(10);
    issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf");
    idle(10);

    issue(MD_MTHI, 32'h12345678, 32'd0, 0, 32'd0, 32'd0, "mthi");
    issue(MD_MTLO, 32'h9ABCDEF0, 32'd0, 0, 32'd0, 32'd0, "mtlo");
    idle(1);
    issue(MD_DIV, 32'h00000005, 32'h00000000, 10, 32'h12345678, 32'h9ABCDEF0, "div_by0");
    idle(10);

    issue(MD_MULT, 32'h00000003, 32'h00000004, 5, 32'h00000000, 32'h0000000C, "mult_stray");
    idle(2);
    stray(MD_MTLO, 32'hDEADBEEF);
    idle(2);
    idle(2);

    issue(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h00000000, 32'h00000001, "mult_reset");
    idle(2);
    do_reset();
    idle(4);

    issue(MD_MULT, 32'h00000007, 32'h00000006, 5, 32'h00000000, 32'h0000002A, "b2b_mult");
    idle(5);
    issue(MD_DIVU, 32'h00000064, 32'h00000007, 10, 32'h00000002, 32'h0000000E, "b2b_divu");
    idle(10);
    idle(3);

    done = 1'b1;
    @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending events, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide sequencer for the pipelined MIPS core. It sits in EX beside the ALU and takes the same two 32-bit operands. It runs mult/multu/div/divu as multi-cycle operations with a busy handshake and owns the architectural HI/LO registers, which mthi/mtlo write and mfhi/mflo read. Decode uses `start | busy` to stall any later MD instruction until the running operation has committed.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu (≥1)
- DIV_CYCLES, 10, busy duration of div/divu (≥1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled only on the rising edge of clk
- indata1  in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- indata2  in  32  rt operand (divisor / multiplier)
- mdop  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
- start  in  1  one-cycle request qualifying mdop and the operands
- busy  out  1  a multi-cycle operation is in flight
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

## Operation
- State machine: IDLE, RUN. A down-counter `cnt` (4 bits at default parameters, sized to max(MULT_CYCLES, DIV_CYCLES)) plus pending registers `p_hi` and `p_lo`.
- IDLE with start=1:
  - mdop 1/2: compute the 64-bit product and load it into {p_hi, p_lo}. mult is signed×signed; multu is unsigned. Set cnt=MULT_CYCLES and go to RUN.
  - mdop 3/4: if indata2≠0, set p_lo=quotient and p_hi=remainder. div uses signed operands, truncates toward zero, and the remainder takes the dividend's sign. divu is unsigned. If indata2=0, load p_hi/p_lo with the current hi/lo, so the commit leaves them unchanged. Either way set cnt=DIV_CYCLES and go to RUN.
  - mdop 5: hi←indata1 at this edge. No busy. Stay in IDLE.
  - mdop 6: lo←indata1 at this edge. No busy. Stay in IDLE.
  - mdop 0/7: no effect.
- RUN: decrement cnt each cycle. When cnt=1 at an edge: hi←p_hi, lo←p_lo, cnt←0, go to IDLE.
- start while in RUN is ignored completely, whatever mdop is. Decode must not issue it; the bench flags it as an upstream violation.
- busy = (state==RUN). It is a registered output.
- hi/lo change only at a commit edge or an mthi/mtlo edge. They hold their value at all other times, including throughout RUN.
- Reset (reset=0 at an edge), whatever the state: state←IDLE, cnt←0, busy←0, hi←0, lo←0, p_hi/p_lo←0. An in-flight result is discarded and never committed. start is ignored in any cycle where reset=0.

## Timing
- Reset values: busy=0, hi=0x00000000, lo=0x00000000.
- mult/multu with start in cycle T:
  - busy=1 in cycles T+1 through T+MULT_CYCLES.
  - New hi/lo visible in cycle T+MULT_CYCLES+1, when busy is already 0.
- div/divu: same as mult with DIV_CYCLES in place of MULT_CYCLES.
- mthi/mtlo at T: new value visible at T+1; busy stays 0.
- Back-to-back: a start is legal in the first cycle with busy=0. That means cycle T+N+1, which sees the committed hi/lo.
- The commit edge and an mthi/mtlo cannot coincide, because start is ignored in RUN.
- hi/lo are register outputs with no combinational path from the inputs.

## Structure
- Shared package `md_pkg`:
  - mdop encodings MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  - default latency constants MULT_CYCLES_D=5, DIV_CYCLES_D=10
  - state enum {MD_IDLE, MD_RUN}
- Arithmetic is computed combinationally at start; the counter only models latency.
- One natural sub-module: `md_div32`, a combinational signed/unsigned 32-bit divide. It takes the sign flag and the operands and returns quotient and remainder. It keeps the sign-fixup logic testable in isolation.
- Everything else stays in `md_unit`.

## Test plan
- Reset, then mult with indata1=0xFFFFFFFF, indata2=0x00000002 → busy high cycles T+1..T+5, hi=0xFFFFFFFF and lo=0xFFFFFFFE at T+6. Repeat with multu → hi=0x00000001, lo=0xFFFFFFFE.
- div with 0xFFFFFFF9 (−7) / 0x00000002 → at T+11 lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 → lo=0x00000003, hi=0x00000001.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 the next cycle → hi and lo each update one cycle after their start, busy never rises. Then div by 0 → after 10 busy cycles hi/lo remain 0x12345678/0x9ABCDEF0.
- mult running; at T+3 assert start with mtlo 0xDEADBEEF → ignored: lo stays at its pre-mult value until T+5, then commits the product; 0xDEADBEEF never appears.
- mult running; reset=0 at T+3 → at T+4 busy=0 and hi=lo=0. At T+6 there is still no commit of the old product.
- Back-to-back: mult, then div issued in the first busy=0 cycle → div issues exactly 6 cycles after mult, both results correct, no gap violations.
